// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and the round/saturate helper.
package fir_pkg;

  localparam int unsigned FIR_ACC_W  = 36;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAC_SHIFT = 15;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // Width of the rounded, shifted accumulator before saturation.
  localparam int unsigned RND_W = FIR_ACC_W + 1 - FRAC_SHIFT;

  localparam logic signed [RND_W-1:0] RND_MAX =
    {{(RND_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] RND_MIN =
    {{(RND_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] sample;
    logic                       clip;
  } sat_result_t;

  // Round half up, arithmetic shift, then clip to the Q1.15 range.
  function automatic sat_result_t sat_round(input logic signed [FIR_ACC_W-1:0] acc);
    logic signed [FIR_ACC_W:0] sum;
    logic signed [RND_W-1:0]   r;
    sat_result_t               res;
    sum = {acc[FIR_ACC_W-1], acc} + ((FIR_ACC_W+1)'(1) << (FRAC_SHIFT - 1));
    r   = RND_W'(sum >>> FRAC_SHIFT);
    res.clip = 1'b0;
    if (r > RND_MAX) begin
      res.sample = SAMPLE_MAX;
      res.clip   = 1'b1;
    end else if (r < RND_MIN) begin
      res.sample = SAMPLE_MIN;
      res.clip   = 1'b1;
    end else begin
      res.sample = SAMPLE_W'(r);
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; a push while full is accepted only alongside a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_requant_decim.sv
// Requantise the FIR accumulator to Q1.15, decimate, and buffer the result.
module fir_requant_decim
  import fir_pkg::*;
#(
  parameter int unsigned IN_W       = FIR_ACC_W,
  parameter int unsigned OUT_W      = SAMPLE_W,
  parameter int unsigned FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
  parameter int unsigned DECIM      = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  input  logic                    clear_stats,
  output logic                    ovf,
  output logic [15:0]             sat_count
);

  localparam int unsigned RW   = IN_W + 1 - FRAC_SHIFT;
  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [RW-1:0] R_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]   sum;
  logic signed [RW-1:0]   r1;
  logic                   v1;
  logic                   keep1;
  logic [PH_W-1:0]        phase;
  logic                   push;
  logic                   clip;
  logic [OUT_W-1:0]       sat_sample;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [OUT_W-1:0]       head;
  logic                   drop;

  // Rounding add carried one bit wider than the input so it cannot wrap.
  always_comb begin
    sum = {in_sample[IN_W-1], in_sample} + ((IN_W+1)'(1) << (FRAC_SHIFT - 1));
  end

  // Stage 1: register the rounded value, valid bit and keep decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      keep1 <= 1'b0;
      r1    <= '0;
      phase <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        r1    <= RW'(sum >>> FRAC_SHIFT);
        keep1 <= (phase == '0);
        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
    end
  end

  // Stage 2: saturate the kept sample and form the FIFO push.
  always_comb begin
    push       = v1 && keep1;
    clip       = 1'b0;
    sat_sample = r1[OUT_W-1:0];
    if (r1 > R_MAX) begin
      sat_sample = {1'b0, {(OUT_W-1){1'b1}}};
      clip       = 1'b1;
    end else if (r1 < R_MIN) begin
      sat_sample = {1'b1, {(OUT_W-1){1'b0}}};
      clip       = 1'b1;
    end
    pop       = !empty && out_ready;
    drop      = push && full && !pop;
    out_valid = !empty;
    out_data  = empty ? '0 : head;
  end

  sync_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(sat_sample),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  // Sticky overflow and saturating clip counter; a new event beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf       <= 1'b0;
      sat_count <= '0;
    end else begin
      if (drop)             ovf <= 1'b1;
      else if (clear_stats) ovf <= 1'b0;

      if (push && clip) begin
        if (clear_stats)              sat_count <= 16'd1;
        else if (sat_count != '1)     sat_count <= sat_count + 16'd1;
      end else if (clear_stats) begin
        sat_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_requant_decim.sv
// Randomised and directed bench for fir_requant_decim against a queue-level model.
module tb_fir_requant_decim;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [35:0] in_sample;
  logic               out_ready;
  logic               clear_stats;

  logic               ov1, ov4, ovf1, ovf4;
  logic signed [15:0] od1, od4;
  logic [15:0]        sc1, sc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_requant_decim #(.IN_W(36), .OUT_W(16), .FRAC_SHIFT(15), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .clear_stats(clear_stats), .ovf(ovf1), .sat_count(sc1));

  fir_requant_decim #(.IN_W(36), .OUT_W(16), .FRAC_SHIFT(15), .DECIM(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .clear_stats(clear_stats), .ovf(ovf4), .sat_count(sc4));

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model state per instance: index 0 is DECIM=1, index 1 is DECIM=4.
  longint fq [2][DEPTH];
  int     fn [2];
  bit     pv [2];
  bit     pk [2];
  longint pr [2];
  longint nv [2];
  bit     movf [2];
  longint msc [2];
  bit     en = 0;
  bit     collect = 0;
  longint got1 [$];
  longint got4 [$];

  function automatic longint rnd(input longint s);
    return (s + 64'sd16384) >>> 15;
  endfunction

  // One clock edge of the model, using the inputs the DUT is about to sample.
  task automatic mstep(input int i, input int d);
    longint v;
    bit clip, drop, pop;
    if (rst) begin
      fn[i] = 0; pv[i] = 0; pk[i] = 0; nv[i] = 0; movf[i] = 0; msc[i] = 0;
      return;
    end
    pop = (fn[i] > 0) && out_ready;
    if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++) fq[i][k] = fq[i][k+1];
      fn[i]--;
    end
    clip = 0;
    drop = 0;
    if (pv[i] && pk[i]) begin
      v = pr[i];
      if (v > 32767) begin v = 32767; clip = 1; end
      else if (v < -32768) begin v = -32768; clip = 1; end
      if (fn[i] < DEPTH) begin fq[i][fn[i]] = v; fn[i]++; end
      else drop = 1;
    end
    if (drop) movf[i] = 1;
    else if (clear_stats) movf[i] = 0;
    if (clip) msc[i] = clear_stats ? 1 : ((msc[i] == 65535) ? 65535 : msc[i] + 1);
    else if (clear_stats) msc[i] = 0;
    pk[i] = in_valid && ((nv[i] % d) == 0);
    pv[i] = in_valid;
    pr[i] = rnd(longint'(in_sample));
    if (in_valid) nv[i]++;
  endtask

  // Compare every cycle away from the active edge, then advance the model.
  always @(negedge clk) begin
    if (en) begin
      chk("d1_valid", ov1, fn[0] > 0);
      if (fn[0] > 0) chk("d1_data", od1, fq[0][0]);
      chk("d1_ovf", ovf1, movf[0]);
      chk("d1_satc", sc1, msc[0]);
      chk("d4_valid", ov4, fn[1] > 0);
      if (fn[1] > 0) chk("d4_data", od4, fq[1][0]);
      chk("d4_ovf", ovf4, movf[1]);
      chk("d4_satc", sc4, msc[1]);
      if (collect && ov1 && out_ready) got1.push_back(longint'(od1));
      if (collect && ov4 && out_ready) got4.push_back(longint'(od4));
    end
    mstep(0, 1);
    mstep(1, 4);
    if (rst) en = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0;
    step();
    rst = 0;
  endtask

  // Single sample, checked literally at t+2 on the DECIM=1 instance.
  task automatic one(input longint s, input longint e, input string nm);
    in_valid = 1; in_sample = 36'(s);
    step();
    in_valid = 0;
    step();
    chk({nm, "_valid"}, ov1, 1);
    chk(nm, od1, e);
    step();
    step();
  endtask

  initial begin
    logic [63:0] w;
    rst = 1; in_valid = 0; in_sample = '0; out_ready = 1; clear_stats = 0;
    step();
    step();
    rst = 0;
    chk("rst_valid", ov1, 0);
    chk("rst_data", od1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_satc", sc1, 0);

    one(100 * 32768, 100, "scale_pos");
    one(-7 * 32768, -7, "scale_neg");
    one(16384, 1, "rnd_16384");
    one(16383, 0, "rnd_16383");
    one(-16384, 0, "rnd_m16384");
    one(-16385, -1, "rnd_m16385");
    chk("rnd_satc", sc1, 0);

    one(64'sd1 <<< 31, 32767, "sat_pos");
    one(-(64'sd1 <<< 31), -32768, "sat_neg");
    chk("sat_count2", sc1, 2);
    clear_stats = 1;
    step();
    clear_stats = 0;
    chk("sat_clear", sc1, 0);

    // Decimation by 4 with a gap after the third input.
    do_reset();
    got4.delete();
    collect = 1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1; in_sample = 36'(k * 32768);
      step();
      if (k == 3) begin
        in_valid = 0;
        step();
        step();
      end
    end
    in_valid = 0;
    repeat (5) step();
    collect = 0;
    chk("dec_count", got4.size(), 2);
    if (got4.size() >= 2) begin
      chk("dec_first", got4[0], 1);
      chk("dec_second", got4[1], 5);
    end

    // Back-pressure with overflow, then drain.
    do_reset();
    out_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1; in_sample = 36'(k * 32768);
      step();
    end
    in_valid = 0;
    repeat (3) step();
    chk("bp_valid", ov1, 1);
    chk("bp_head", od1, 1);
    chk("bp_ovf", ovf1, 1);
    got1.delete();
    collect = 1;
    out_ready = 1;
    repeat (8) step();
    collect = 0;
    chk("drain_count", got1.size(), 4);
    for (int k = 0; k < 4; k++)
      if (got1.size() > k) chk("drain_order", got1[k], k + 1);
    chk("drain_empty", ov1, 0);

    // Full FIFO with simultaneous push and pop on a continuous stream.
    clear_stats = 1;
    step();
    clear_stats = 0;
    chk("clr_ovf", ovf1, 0);
    out_ready = 0;
    for (int k = 11; k <= 14; k++) begin
      in_valid = 1; in_sample = 36'(k * 32768);
      step();
    end
    out_ready = 1;
    for (int k = 15; k <= 30; k++) begin
      in_valid = 1; in_sample = 36'(k * 32768);
      step();
    end
    chk("stream_ovf", ovf1, 0);

    // Reset mid-stream; the first valid input afterwards must be kept.
    in_sample = 36'(100 * 32768);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_valid", ov1, 0);
    chk("mrst_ovf", ovf1, 0);
    in_valid = 1; in_sample = 36'(200 * 32768);
    step();
    in_sample = 36'(201 * 32768);
    step();
    chk("mrst_first1", od1, 200);
    chk("mrst_first4", od4, 200);
    in_valid = 0;
    repeat (4) step();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin w = {$urandom(), $urandom()}; in_sample = w[35:0]; end
        1: in_sample = 36'($signed({1'b0, $urandom_range(0, 2097152)}) - 1048576);
        2: in_sample = 36'(longint'(32767) * 32768 + longint'($urandom_range(0, 65536)) - 32768);
        default: in_sample = 36'(-longint'(32768) * 32768 + longint'($urandom_range(0, 65536)) - 32768);
      endcase
      out_ready   = ($urandom_range(0, 2) != 0);
      clear_stats = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; in_valid = 0; clear_stats = 0; out_ready = 1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_requant_decim.md
Name: fir_requant_decim

Overview:
- Downstream stage of the 16-tap FIR. Consumes the FIR's 36-bit signed accumulator output once per clock.
- Rounds and shifts it back to 16-bit Q1.15, saturates, and decimates by DECIM.
- Buffers the results in a small FIFO behind a valid/ready output, so a stalling consumer does not need to stall the free-running FIR. Overflow and saturation events are reported through sticky status and a counter.

Parameters:
- IN_W, 36, input accumulator width (Q2.30 product sum from the FIR).
- OUT_W, 16, output sample width (Q1.15).
- FRAC_SHIFT, 15, right-shift applied after rounding.
- DECIM, 1, decimation ratio: keep 1 of every DECIM valid inputs. Legal range 1..256.
- FIFO_DEPTH, 4, output buffer entries. Must be a power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock, shared with the FIR.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample qualifier; tied to 1 when the FIR drives this block directly.
- in_sample  in  IN_W  signed FIR output.
- out_valid  out  1  FIFO head holds a sample.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  OUT_W  signed Q1.15 sample at the FIFO head.
- clear_stats  in  1  single-cycle pulse; clears ovf and sat_count.
- ovf  out  1  sticky: a decimated sample was dropped because the FIFO was full.
- sat_count  out  16  number of saturated decimated samples; saturates at 16'hFFFF.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state is cleared only on the rising clk edge with rst=1.
- Reset values:
  - out_valid=0, out_data=0, ovf=0, sat_count=0.
  - Phase counter=0, FIFO empty.
  - Pipeline valid bits=0.
- Stage 1 (register): when in_valid=1, compute r = (in_sample + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT.
  - Round half up; arithmetic shift.
  - Add performed at IN_W+1 bits, so there is no wrap.
  - Register r together with v1=in_valid.
- Decimation:
  - Phase counter advances only on in_valid=1 and wraps at DECIM-1.
  - A sample is kept when phase==0 at its stage-1 capture, so the first valid input after reset is kept.
  - DECIM=1 keeps every sample.
- Stage 2 (register into FIFO): if the stage-1 sample is kept:
  - Saturate r to [-32768, 32767].
  - Set sat flag if clipped.
  - Push into the FIFO.
- Latency: a sample presented with in_valid in cycle t appears at out_data with out_valid=1 in cycle t+2 if the FIFO was empty.
- Output handshake:
  - A pop occurs when out_valid && out_ready.
  - out_data is the FIFO head, in order.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - out_data is don't-care when out_valid=0.
- FIFO boundaries:
  - Push and pop in the same cycle are always allowed, including when full (the count is unchanged) and when empty (pop is impossible since out_valid=0).
  - Push when full without a simultaneous pop: the new sample is dropped, FIFO contents are unchanged, and ovf is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Status:
  - sat_count increments by 1 per kept, clipped sample and stops at 16'hFFFF.
  - Dropped samples that clipped are still counted.
  - clear_stats and a new event in the same cycle: the result is ovf=1 / sat_count=1 (the event wins over clear).
- Reset mid-operation: in-flight pipeline samples and FIFO contents are discarded, and the phase restarts at 0.

Decomposition:
- Shared package fir_pkg:
  - FIR_ACC_W=36, SAMPLE_W=16, FRAC_SHIFT=15.
  - SAMPLE_MAX/SAMPLE_MIN constants.
  - A pure function sat_round(acc) returning the rounded, saturated sample plus a clip flag, reusable by the FIR bench model.
- Sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head).
- fir_requant_decim instantiates one sync_fifo. Pipeline, decimation and status logic are local.

Test Plan:
- Scaling: DECIM=1, in_sample = 100·2^15, 1 cycle -> out_data=100 at t+2; -7·2^15 -> -7.
- Rounding: in_sample=16384 -> 1; 16383 -> 0; -16384 -> 0; -16385 -> -1. sat_count stays 0.
- Saturation: in_sample=2^31 -> 32767; in_sample=-2^31 -> -32768. sat_count=2. clear_stats -> sat_count=0 the next cycle.
- Decimation: DECIM=4, inputs k·2^15 for k=1..8 with an in_valid gap after k=3 -> outputs exactly 1, 5. The gap must not shift the phase.
- Back-pressure/overflow: DECIM=1, FIFO_DEPTH=4, out_ready=0, 6 samples 1..6 -> out_valid stays 1 with out_data=1 stable and ovf=1. Then out_ready=1 -> drains 1,2,3,4 in order, then out_valid=0.
- Full push+pop and reset: FIFO full, out_ready=1 with a continuous input stream -> no ovf, order preserved. Assert rst for 1 cycle mid-stream -> out_valid=0, ovf=0, and the next kept sample is the first valid input after reset.
